alarm_controller: RTL

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller
//
// Alarm-clock control block. It holds the alarm time, compares it with the
// running BCD time of day and steps through IDLE / ARMED / RINGING / SNOOZE
// in response to the match and to the button pulses. The ring lasts
// RING_SEC seconds with a 1 Hz beep cadence. Snooze waits SNOOZE_MIN
// minutes and then rings again. Snooze can be repeated any number of times.
//
// Parameters
//   RING_SEC     ringing duration in 1 Hz ticks (1..255)
//   SNOOZE_MIN   snooze length in minutes (1..30)
//   RST_HH       alarm hour (BCD) after reset
//   RST_MM       alarm minute (BCD) after reset
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   clk_1hz_tick  one-cycle pulse once per second
//   cur_hh/mm/ss  current time of day, BCD
//   set_en        time-setting mode; alarm matches are suppressed while high
//   alm_hh_in     new alarm hour (BCD)
//   alm_mm_in     new alarm minute (BCD)
//   alm_load      one-cycle pulse; loads alm_*_in if it is a legal BCD time
//   arm_p         button pulse: toggles armed/disarmed, cancels ring/snooze
//   stop_p        button pulse: ends ring/snooze and stays armed
//   snooze_p      button pulse: moves a ringing alarm into snooze
//   alm_hh/alm_mm stored alarm time (BCD)
//   armed         high in ARMED, RINGING and SNOOZE
//   ringing       high in RINGING only
//   buzzer        ringing gated by the beep phase
// ---------------------------------------------------------------------------
module alarm_controller #(
  parameter int         RING_SEC   = 60,
  parameter int         SNOOZE_MIN = 5,
  parameter logic [7:0] RST_HH     = 8'h07,
  parameter logic [7:0] RST_MM     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_tick,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       set_en,
  input  logic [7:0] alm_hh_in,
  input  logic [7:0] alm_mm_in,
  input  logic       alm_load,
  input  logic       arm_p,
  input  logic       stop_p,
  input  logic       snooze_p,
  output logic [7:0] alm_hh,
  output logic [7:0] alm_mm,
  output logic       armed,
  output logic       ringing,
  output logic       buzzer
);

  // State encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_RINGING = 2'd2;
  localparam logic [1:0] S_SNOOZE  = 2'd3;

  // Last ring_cnt value before the ring times out.
  localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);
  // Snooze length in seconds; SNOOZE_MIN <= 30 keeps this within 11 bits.
  localparam logic [10:0] SNZ_LOAD  = 11'(SNOOZE_MIN * 60);

  // Registered state
  logic [1:0]  r_state;
  logic [7:0]  r_alm_hh;
  logic [7:0]  r_alm_mm;
  logic [7:0]  r_ring_cnt;
  logic [10:0] r_snz_cnt;
  logic        r_beep_phase;
  logic        r_match_d;

  // Combinational helpers
  logic [1:0]  w_state_next;
  logic        w_match;
  logic        w_match_evt;
  logic        w_enter_ring;
  logic        w_enter_snz;
  logic        w_load_ok;
  logic        w_ring_tick;
  logic        w_snz_tick;

  // A BCD byte is legal when both nibbles are decimal digits and the
  // value does not exceed the given BCD upper bound.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v <= max_v) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  assign w_load_ok = bcd_ok(alm_hh_in, 8'h23) && bcd_ok(alm_mm_in, 8'h59);

  // The match holds for the whole matching second. Only its rising edge
  // counts. A ring dismissed inside that second therefore does not
  // re-trigger.
  assign w_match     = (cur_hh == r_alm_hh) && (cur_mm == r_alm_mm) &&
                       (cur_ss == 8'h00) && !set_en;
  assign w_match_evt = w_match && !r_match_d;

  // Next-state logic. The button priority is arm > stop > snooze > timers.
  always_comb begin
    w_state_next = r_state;
    w_enter_ring = 1'b0;
    w_enter_snz  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm_p) begin
          w_state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        // A disarm in the same cycle as a match swallows the match.
        if (arm_p) begin
          w_state_next = S_IDLE;
        end else if (w_match_evt) begin
          w_state_next = S_RINGING;
          w_enter_ring = 1'b1;
        end
      end
      S_RINGING: begin
        if (arm_p) begin
          w_state_next = S_IDLE;
        end else if (stop_p) begin
          w_state_next = S_ARMED;
        end else if (snooze_p) begin
          w_state_next = S_SNOOZE;
          w_enter_snz  = 1'b1;
        end else if (clk_1hz_tick && (r_ring_cnt == RING_LAST)) begin
          w_state_next = S_ARMED;
        end
      end
      S_SNOOZE: begin
        if (arm_p) begin
          w_state_next = S_IDLE;
        end else if (stop_p) begin
          w_state_next = S_ARMED;
        end else if (clk_1hz_tick && (r_snz_cnt == 11'd1)) begin
          w_state_next = S_RINGING;
          w_enter_ring = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Counters advance only on ticks where the state does not change.
  // Leaving the state makes their value irrelevant. Entering it reloads them.
  assign w_ring_tick = (r_state == S_RINGING) && (w_state_next == S_RINGING) &&
                       clk_1hz_tick;
  assign w_snz_tick  = (r_state == S_SNOOZE) && (w_state_next == S_SNOOZE) &&
                       clk_1hz_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_alm_hh     <= RST_HH;
      r_alm_mm     <= RST_MM;
      r_ring_cnt   <= 8'd0;
      r_snz_cnt    <= 11'd0;
      r_beep_phase <= 1'b0;
      r_match_d    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_match_d <= w_match;

      // Beep phase starts high so the buzzer sounds on the first ring cycle.
      if (w_enter_ring) begin
        r_ring_cnt   <= 8'd0;
        r_beep_phase <= 1'b1;
      end else if (w_ring_tick) begin
        r_ring_cnt   <= r_ring_cnt + 8'd1;
        r_beep_phase <= ~r_beep_phase;
      end

      if (w_enter_snz) begin
        r_snz_cnt <= SNZ_LOAD;
      end else if (w_snz_tick) begin
        r_snz_cnt <= r_snz_cnt - 11'd1;
      end

      // Loading a new alarm time never disturbs the state machine.
      if (alm_load && w_load_ok) begin
        r_alm_hh <= alm_hh_in;
        r_alm_mm <= alm_mm_in;
      end
    end
  end

  // Outputs are decoded purely from registers.
  assign alm_hh  = r_alm_hh;
  assign alm_mm  = r_alm_mm;
  assign armed   = (r_state != S_IDLE);
  assign ringing = (r_state == S_RINGING);
  assign buzzer  = (r_state == S_RINGING) && r_beep_phase;

endmodule
